// File: rtl/diod_pkg.sv
// Shared definitions for the diode controller: arbiter FSM state codes,
// the default DAC word width and a saturating timer increment.
package diod_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    WAIT_LOW  = ST_WAIT_LOW,
    WAIT_HIGH = ST_WAIT_HIGH,
    GAP       = ST_GAP
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from pointer+1, wrapping at N_CH.
module rr_pick #(
  parameter int N_CH = 2,
  parameter int PW   = 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  logic [PW-1:0] cand [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
      assign cand[gi] = PW'((int'(pointer) + gi + 1) % N_CH);
    end
  endgenerate

  // Walk from the farthest candidate back so the nearest one wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        winner = cand[k];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_dac_arbiter.sv
// Round-robin arbiter sharing one spi_module DAC link between N_CH channel
// controllers; tracks each frame on SS, then acks the owner or flags a timeout.
module spi_dac_arbiter
  import diod_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int GAP_CYC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*DATA_W-1:0]   req_data,
  input  logic                     spi_ss,
  output logic                     spi_start,
  output logic [DATA_W-1:0]        spi_data,
  output logic [N_CH-1:0]          grant,
  output logic [N_CH-1:0]          ack,
  output logic                     err,
  output logic                     busy,
  output logic [2:0]               debug_state
);

  localparam int         PW        = $clog2(N_CH);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [3:0] GAP_LAST  = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

  logic [DATA_W-1:0] words [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_words
      assign words[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  state_t            state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [3:0]        gap_q, gap_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [N_CH-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [PW-1:0] pick_winner;
  logic          pick_valid;
  logic [7:0]    timer_inc;

  rr_pick #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_rr_pick (
    .req     (req),
    .pointer (ptr_q),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  assign timer_inc = sat_inc8(timer_q);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    start_d = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d[pick_winner] = 1'b1;
          data_d  = words[pick_winner];
          ptr_d   = pick_winner;
          state_d = START;
        end
      end
      // Start is registered, so its pulse lands in the first WAIT_LOW cycle.
      START: begin
        start_d = 1'b1;
        timer_d = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!spi_ss) begin
          timer_d = '0;
          state_d = WAIT_HIGH;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TIMEOUT_C) begin
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      WAIT_HIGH: begin
        if (spi_ss) begin
          ack_d   = grant_q;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TIMEOUT_C) begin
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      gap_q   <= '0;
      ptr_q   <= PW'(N_CH - 1);
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      start_q <= start_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign spi_start   = start_q;
  assign spi_data    = data_q;
  assign grant       = grant_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_spi_dac_arbiter.sv
// Scoreboard bench for spi_dac_arbiter: directed requests push expected frames
// and acks; a negedge monitor pops and compares whenever the DUT presents them.
module tb_spi_dac_arbiter;

  localparam int N_CH    = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 255;
  localparam int GAP_CYC = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N_CH-1:0]   req = '0;
  logic [N_CH*DATA_W-1:0] req_data = '0;
  logic              spi_ss = 1'b1;
  logic              spi_start;
  logic [DATA_W-1:0] spi_data;
  logic [N_CH-1:0]   grant;
  logic [N_CH-1:0]   ack;
  logic              err;
  logic              busy;
  logic [2:0]        debug_state;

  always #5 clk = ~clk;

  spi_dac_arbiter #(
    .N_CH    (N_CH),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .spi_ss      (spi_ss),
    .spi_start   (spi_start),
    .spi_data    (spi_data),
    .grant       (grant),
    .ack         (ack),
    .err         (err),
    .busy        (busy),
    .debug_state (debug_state)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] grant;
  } frame_t;

  frame_t exp_frames[$];
  frame_t exp_acks[$];
  int     exp_errs = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cnt = 0, ack_cnt = 0, err_cnt = 0;
  int last_start_cyc = 0, last_ack_cyc = 0, last_err_cyc = 0, last_idle_cyc = 0;
  bit ss_stuck = 1'b0;
  int ss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // spi_module model: SS goes low 3 cycles after start, for 16 cycles.
  initial forever begin
    @(negedge clk);
    if (reset) ss_cnt = 0;
    else if (spi_start && !ss_stuck) ss_cnt = 19;
    else if (ss_cnt != 0) ss_cnt--;
    spi_ss = !(ss_cnt >= 1 && ss_cnt <= 16);
  end

  initial begin : monitor
    frame_t f;
    bit busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_prev && !busy) last_idle_cyc = cyc;
      busy_prev = busy;
      if (spi_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (exp_frames.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: got data %0h grant %0b expected no start", spi_data, grant);
        end else begin
          f = exp_frames.pop_front();
          chk("frame_data", 32'(spi_data), 32'(f.data));
          chk("frame_grant", 32'(grant), 32'(f.grant));
        end
        $display("cyc %0d start data=%0h grant=%0b", cyc, spi_data, grant);
      end
      if (ack != 0) begin
        ack_cnt++;
        last_ack_cyc = cyc;
        if (exp_acks.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got %0b expected none", ack);
        end else begin
          f = exp_acks.pop_front();
          chk("ack", 32'(ack), 32'(f.grant));
          chk("ack_data_held", 32'(spi_data), 32'(f.data));
        end
        $display("cyc %0d ack=%0b data=%0h", cyc, ack, spi_data);
      end
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
        if (exp_errs == 0) begin
          total++; bad++;
          $display("FAIL unexpected_err: got err=1 expected none");
        end else begin
          exp_errs--;
        end
        $display("cyc %0d err", cyc);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin step(); n++; end
    if (ack_cnt < target) begin
      total++; bad++;
      $display("FAIL wait_ack: got %0d acks expected %0d", ack_cnt, target);
    end
  endtask

  task automatic wait_err(input int target, input int budget);
    int n = 0;
    while (err_cnt < target && n < budget) begin step(); n++; end
    if (err_cnt < target) begin
      total++; bad++;
      $display("FAIL wait_err: got %0d errs expected %0d", err_cnt, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL wait_idle: got busy=1 expected 0");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int req_cyc, base, n, s0;
    frame_t fr;

    // Reset state and quiet link
    do_reset();
    chk("reset_outputs", {spi_start, spi_data, grant, ack, err, busy, debug_state}, 0);
    s0 = start_cnt;
    n = 0;
    repeat (100) begin step(); if (busy) n++; end
    chk("idle_no_start", start_cnt - s0, 0);
    chk("idle_busy_cycles", n, 0);

    // Single request, latency and gap length
    req_data[7:0] = 8'hA5;
    fr.data = 8'hA5; fr.grant = 2'b01;
    exp_frames.push_back(fr);
    exp_acks.push_back(fr);
    base = ack_cnt;
    req = 2'b01;
    req_cyc = cyc;
    wait_ack(base + 1, 100);
    req = '0;
    chk("start_latency", last_start_cyc - req_cyc, 2);
    wait_idle(50);
    chk("gap_after_ack", last_idle_cyc - last_ack_cyc, GAP_CYC);

    // Both channels held: rotation 0,1,0,1
    do_reset();
    req_data = {8'h20, 8'h10};
    for (int i = 0; i < 4; i++) begin
      fr.data  = (i % 2 == 0) ? 8'h10 : 8'h20;
      fr.grant = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_frames.push_back(fr);
      exp_acks.push_back(fr);
    end
    base = ack_cnt;
    req = 2'b11;
    wait_ack(base + 4, 400);
    req = '0;
    wait_idle(50);

    // SS stuck high: timeout abort
    do_reset();
    ss_stuck = 1'b1;
    req_data[7:0] = 8'h5A;
    fr.data = 8'h5A; fr.grant = 2'b01;
    exp_frames.push_back(fr);
    exp_errs++;
    base = err_cnt;
    s0 = ack_cnt;
    req = 2'b01;
    wait_err(base + 1, 400);
    req = '0;
    chk("timeout_cycles", last_err_cyc - last_start_cyc, TIMEOUT);
    wait_idle(50);
    chk("gap_after_err", last_idle_cyc - last_err_cyc, GAP_CYC);
    chk("no_ack_on_timeout", ack_cnt - s0, 0);
    ss_stuck = 1'b0;

    // Reset during WAIT_HIGH
    do_reset();
    req_data[7:0] = 8'h77;
    fr.data = 8'h77; fr.grant = 2'b01;
    exp_frames.push_back(fr);
    req = 2'b01;
    n = 0;
    while (debug_state != 3'd3 && n < 60) begin step(); n++; end
    chk("reached_wait_high", 32'(debug_state), 3);
    reset = 1'b1;
    req = '0;
    step();
    chk("reset_midframe", {spi_start, spi_data, grant, ack, err, busy, debug_state}, 0);
    reset = 1'b0;
    step();
    req_data[15:8] = 8'h66;
    fr.data = 8'h66; fr.grant = 2'b10;
    exp_frames.push_back(fr);
    exp_acks.push_back(fr);
    base = ack_cnt;
    req = 2'b10;
    wait_ack(base + 1, 100);
    req = '0;
    wait_idle(50);

    // Word change after grant is ignored
    do_reset();
    req_data[15:8] = 8'h33;
    fr.data = 8'h33; fr.grant = 2'b10;
    exp_frames.push_back(fr);
    exp_acks.push_back(fr);
    base = ack_cnt;
    req = 2'b10;
    n = 0;
    while (grant == '0 && n < 20) begin step(); n++; end
    chk("grant_seen", 32'(grant), 32'(2'b10));
    step();
    req_data[15:8] = 8'h44;
    n = 0;
    while (debug_state != 3'd3 && n < 60) begin step(); n++; end
    chk("data_mid_frame", 32'(spi_data), 32'h33);
    wait_ack(base + 1, 100);
    req = '0;
    wait_idle(50);

    repeat (5) step();
    chk("frames_left", exp_frames.size(), 0);
    chk("acks_left", exp_acks.size(), 0);
    chk("errs_left", exp_errs, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
